side_vehicle_detector: RTL and testbench
========================================

# side_vehicle_detector

Upstream conditioner for the traffic light controller's `sensor` input. It synchronises and debounces the raw side-road inductive-loop signal, counts queued vehicles, and raises a registered request. The request fires when enough cars are waiting or the first car has waited too long. It observes the controller's `side_road` light code, drops the request, and clears the queue once side-road green is granted.

## Interface
- `DEBOUNCE`, 3: consecutive synchronised samples required to accept a loop level change (≥1)
- `MIN_CARS`, 2: queue depth that raises the request immediately (≥1)
- `MAX_WAIT`, 20: cycles in WAITING before the request is forced (≥1)
- `CNT_W`, 4: width of `car_count`; saturates at 2^CNT_W−1
- `clock`, in, 1: system clock, rising edge
- `reset`, in, 1: asynchronous, active-high; reset reset, clock clock
- `loop_raw`, in, 1: raw loop detector, asynchronous to `clock`
- `side_road`, in, 2: controller side-road light code; 2'b01 = green
- `sensor`, out, 1: registered request to the controller
- `car_count`, out, CNT_W: registered vehicles queued since last service
- `car_pulse`, out, 1: registered one-cycle pulse per accepted vehicle arrival

## Operation
- Reset (async, immediate) clears the following to 0: sync flops, `filtered`, debounce counter, `wait_cnt`, `car_count`, `car_pulse`, `sensor`. State = IDLE.
- Synchroniser: two flops, `loop_raw` → `s1` → `s2`.
- Debounce:
  - The counter increments while `s2 != filtered` and resets to 0 when `s2 == filtered`.
  - When the counter reaches DEBOUNCE, `filtered` takes `s2` and the counter clears.
- Arrival: a `filtered` 0→1 transition registers `car_pulse`=1 for exactly one cycle. On the same edge, `car_count` increments (saturating), except in SERVICE.
- FSM:
  - IDLE (`car_count`==0, `sensor`=0): go to WAITING on an arrival; `wait_cnt` clears to 0.
  - WAITING (`sensor`=0): `wait_cnt` increments each cycle, saturating at MAX_WAIT. Go to REQUEST when `car_count`≥MIN_CARS or `wait_cnt`==MAX_WAIT, evaluated on registered values.
  - REQUEST (`sensor`=1): keep counting arrivals. Go to SERVICE when `side_road`==2'b01.
  - SERVICE (`sensor`=0): `car_count` is held at 0 and arrivals still pulse but are not counted. Go to IDLE when `side_road`!=2'b01.
- If `side_road`==2'b01 is seen in IDLE or WAITING (green without request), go to SERVICE. `car_count` and `wait_cnt` clear.
- If an arrival and the green observation occur on the same edge, the clear wins and `car_count` is 0.
- `sensor` is driven only from the registered state (REQUEST), so it is glitch-free.

## Timing
- `loop_raw` stable from before edge n:
  - `s2` reflects it after edge n+1.
  - `filtered` and `car_pulse` update at edge n+DEBOUNCE+1.
- `car_count` updates on the same edge as `car_pulse`.
- Queue trigger: `sensor` rises one edge after the edge where `car_count` reaches MIN_CARS.
- Wait trigger: WAITING entered at edge e gives `wait_cnt`==MAX_WAIT at edge e+MAX_WAIT. `sensor` rises at edge e+MAX_WAIT+1.
- MIN_CARS=1: `sensor` rises one edge after the first arrival.
- Green observed at edge g (`side_road`==01 sampled): `sensor`=0 and `car_count`=0 after edge g.
- Pulses on `loop_raw` shorter than DEBOUNCE synchronised cycles never reach `filtered`.

## Test plan
- Reset with `loop_raw`=1, `side_road`=10 → all outputs 0. Releasing reset gives the first `car_pulse` at release edge + DEBOUNCE + 1.
- DEBOUNCE=3, `loop_raw` high for 2 cycles then low → no `car_pulse`, `car_count`=0, `sensor`=0.
- MIN_CARS=2, two clean vehicles (high 6 / low 6 / high 6) → `car_count` 1 then 2; `sensor` rises exactly one edge after the count reaches 2.
- MAX_WAIT=20, single vehicle → `car_count`=1; `sensor` rises 21 edges after WAITING entry.
- REQUEST, then `side_road`=01 → next edge `sensor`=0, `car_count`=0. A vehicle during green gives `car_pulse`=1 with count 0. Then `side_road`=00 → IDLE, and the next car counts as 1.
- CNT_W=2 with 5 vehicles while red → `car_count` saturates at 3. Asserting reset mid-REQUEST drops `sensor` to 0 before the next clock edge.

Source files
------------

// File: rtl/side_vehicle_detector_if.sv
// -----------------------------------------------------------------------------
// side_vehicle_detector_if
// Signal bundle between the side-road loop detector and its surroundings.
//
//   loop_raw  : raw inductive-loop level, asynchronous to the clock
//   side_road : traffic controller side-road light code (2'b01 = green)
//   sensor    : registered vehicle request towards the controller
//   car_count : registered number of queued vehicles
//   car_pulse : registered one-cycle pulse per accepted vehicle arrival
//
// Modports:
//   master : the environment (loop hardware + controller side), drives the
//            raw loop level and the light code, observes the results
//   slave  : the detector itself
// -----------------------------------------------------------------------------
interface side_vehicle_detector_if #(
   parameter int unsigned CNT_W = 32'd4
);
   logic             loop_raw;
   logic [1:0]       side_road;
   logic             sensor;
   logic [CNT_W-1:0] car_count;
   logic             car_pulse;

   modport master (
      output loop_raw,
      output side_road,
      input  sensor,
      input  car_count,
      input  car_pulse
   );

   modport slave (
      input  loop_raw,
      input  side_road,
      output sensor,
      output car_count,
      output car_pulse
   );
endinterface

// File: rtl/side_vehicle_detector.sv
// -----------------------------------------------------------------------------
// side_vehicle_detector
// Conditions the side-road inductive loop for the traffic light controller:
// synchronises and debounces the raw loop level, counts queued vehicles and
// raises a registered request once enough cars wait or the first car has
// waited too long. The request is withdrawn and the queue cleared as soon as
// the controller shows side-road green.
//
// Parameters:
//   DEBOUNCE : consecutive synchronised samples needed to accept a level change
//   MIN_CARS : queue depth that raises the request immediately
//   MAX_WAIT : cycles in WAITING before the request is forced
//   CNT_W    : width of car_count (saturating)
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : slave side of side_vehicle_detector_if
//           (loop_raw, side_road in; sensor, car_count, car_pulse out)
// -----------------------------------------------------------------------------
module side_vehicle_detector #(
   parameter int unsigned DEBOUNCE = 32'd3,
   parameter int unsigned MIN_CARS = 32'd2,
   parameter int unsigned MAX_WAIT = 32'd20,
   parameter int unsigned CNT_W    = 32'd4
) (
   input  logic                   clock,
   input  logic                   reset,
   side_vehicle_detector_if.slave bus
);

   // The debounce counter only has to hold 0 .. DEBOUNCE-1: the sample that
   // would bring it to DEBOUNCE is the one that updates filtered instead.
   localparam int unsigned DB_W  = (DEBOUNCE > 32'd1) ? $clog2(DEBOUNCE) : 32'd1;
   localparam int unsigned WT_W  = $clog2(MAX_WAIT + 32'd1);
   localparam int unsigned CQ_W  = CNT_W + 32'd1;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 32'd1);
   localparam logic [DB_W-1:0]  DB_ZERO  = DB_W'(32'd0);
   localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(32'd1);
   localparam logic [WT_W-1:0]  WT_MAX   = WT_W'(MAX_WAIT);
   localparam logic [WT_W-1:0]  WT_ZERO  = WT_W'(32'd0);
   localparam logic [WT_W-1:0]  WT_ONE   = WT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   // One extra bit so MIN_CARS above the counter range is never reached
   // instead of wrapping to a small threshold.
   localparam logic [CQ_W-1:0]  MIN_Q    = CQ_W'(MIN_CARS);
   localparam logic [1:0]       SR_GREEN = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAITING = 2'd1,
      ST_REQUEST = 2'd2,
      ST_SERVICE = 2'd3
   } state_t;

   // Saturating increment of the vehicle counter.
   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == CNT_MAX) begin
         result = value;
      end else begin
         result = value + CNT_ONE;
      end
      return result;
   endfunction

   // Saturating increment of the wait timer.
   function automatic logic [WT_W-1:0] wait_sat_inc(input logic [WT_W-1:0] value);
      logic [WT_W-1:0] result;
      if (value == WT_MAX) begin
         result = value;
      end else begin
         result = value + WT_ONE;
      end
      return result;
   endfunction

   logic             s1_r;
   logic             s2_r;
   logic             filtered_r;
   logic [DB_W-1:0]  db_cnt_r;
   logic [WT_W-1:0]  wait_cnt_r;
   logic [CNT_W-1:0] car_count_r;
   logic             car_pulse_r;
   logic             sensor_r;
   state_t           state_r;

   state_t           state_nxt_s;
   logic             filtered_nxt_s;
   logic [DB_W-1:0]  db_cnt_nxt_s;
   logic             db_accept_s;
   logic             arrival_s;
   logic             green_s;
   logic             queue_full_s;
   logic             wait_expired_s;
   logic [WT_W-1:0]  wait_cnt_nxt_s;
   logic [CNT_W-1:0] car_count_nxt_s;
   logic             sensor_nxt_s;

   // Two-flop synchroniser for the asynchronous loop level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= bus.loop_raw;
         s2_r <= s1_r;
      end
   end

   // Debounce: a differing sample that would complete the run of DEBOUNCE
   // is accepted on the same edge, so filtered moves DEBOUNCE edges after
   // the first differing synchronised sample.
   always_comb begin
      db_cnt_nxt_s   = db_cnt_r;
      filtered_nxt_s = filtered_r;
      db_accept_s    = 1'b0;
      if (s2_r != filtered_r) begin
         if (db_cnt_r == DB_LAST) begin
            db_accept_s    = 1'b1;
            filtered_nxt_s = s2_r;
            db_cnt_nxt_s   = DB_ZERO;
         end else begin
            db_cnt_nxt_s   = db_cnt_r + DB_ONE;
         end
      end else begin
         db_cnt_nxt_s = DB_ZERO;
      end
   end

   // Trigger conditions seen by the FSM; all evaluated on registered values.
   assign arrival_s      = db_accept_s & s2_r;
   assign green_s        = (bus.side_road == SR_GREEN);
   assign queue_full_s   = ({1'b0, car_count_r} >= MIN_Q);
   assign wait_expired_s = (wait_cnt_r == WT_MAX);

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; green always takes priority so an unrequested
   // green still clears the queue.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (green_s) begin
               state_nxt_s = ST_SERVICE;
            end else if (arrival_s) begin
               state_nxt_s = ST_WAITING;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAITING: begin
            if (green_s) begin
               state_nxt_s = ST_SERVICE;
            end else if (queue_full_s || wait_expired_s) begin
               state_nxt_s = ST_REQUEST;
            end else begin
               state_nxt_s = ST_WAITING;
            end
         end
         ST_REQUEST: begin
            if (green_s) begin
               state_nxt_s = ST_SERVICE;
            end else begin
               state_nxt_s = ST_REQUEST;
            end
         end
         ST_SERVICE: begin
            if (green_s) begin
               state_nxt_s = ST_SERVICE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: next values of the request, wait timer and vehicle count.
   always_comb begin
      sensor_nxt_s    = (state_nxt_s == ST_REQUEST);
      wait_cnt_nxt_s  = WT_ZERO;
      car_count_nxt_s = car_count_r;

      // The timer runs only while staying in WAITING; entering WAITING or
      // leaving it returns it to zero.
      if ((state_r == ST_WAITING) && (state_nxt_s == ST_WAITING)) begin
         wait_cnt_nxt_s = wait_sat_inc(wait_cnt_r);
      end else begin
         wait_cnt_nxt_s = WT_ZERO;
      end

      // Being in or entering SERVICE pins the queue to zero, which also makes
      // the clear win over an arrival on the green edge.
      if ((state_r == ST_SERVICE) || (state_nxt_s == ST_SERVICE)) begin
         car_count_nxt_s = CNT_ZERO;
      end else if (arrival_s) begin
         car_count_nxt_s = cnt_sat_inc(car_count_r);
      end else begin
         car_count_nxt_s = car_count_r;
      end
   end

   // Debounce state, counters and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         filtered_r  <= 1'b0;
         db_cnt_r    <= DB_ZERO;
         wait_cnt_r  <= WT_ZERO;
         car_count_r <= CNT_ZERO;
         car_pulse_r <= 1'b0;
         sensor_r    <= 1'b0;
      end else begin
         filtered_r  <= filtered_nxt_s;
         db_cnt_r    <= db_cnt_nxt_s;
         wait_cnt_r  <= wait_cnt_nxt_s;
         car_count_r <= car_count_nxt_s;
         car_pulse_r <= arrival_s;
         sensor_r    <= sensor_nxt_s;
      end
   end

   assign bus.sensor    = sensor_r;
   assign bus.car_count = car_count_r;
   assign bus.car_pulse = car_pulse_r;

endmodule

// File: tb/tb_side_vehicle_detector.sv
// -----------------------------------------------------------------------------
// tb_side_vehicle_detector
// Two detector instances with different parameter sets share one stimulus
// stream. A reference model derives the expected outputs from the behavioural
// rules (sample history, run lengths, edge arithmetic) and every output of
// both instances is compared after every clock edge. A few directed latency
// checks are measured against constants derived from the timing rules.
// -----------------------------------------------------------------------------
module tb_side_vehicle_detector;

   localparam int A_DB  = 3;
   localparam int A_MIN = 2;
   localparam int A_MAX = 20;
   localparam int A_CW  = 4;
   localparam int B_DB  = 2;
   localparam int B_MIN = 1;
   localparam int B_MAX = 5;
   localparam int B_CW  = 2;

   logic clock;
   logic reset;

   side_vehicle_detector_if #(.CNT_W(A_CW)) bus_a ();
   side_vehicle_detector_if #(.CNT_W(B_CW)) bus_b ();

   side_vehicle_detector #(
      .DEBOUNCE (A_DB),
      .MIN_CARS (A_MIN),
      .MAX_WAIT (A_MAX),
      .CNT_W    (A_CW)
   ) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   side_vehicle_detector #(
      .DEBOUNCE (B_DB),
      .MIN_CARS (B_MIN),
      .MAX_WAIT (B_MAX),
      .CNT_W    (B_CW)
   ) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_vec;
   int n_bad;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int p_db(input int i);   return (i == 0) ? A_DB  : B_DB;  endfunction
   function automatic int p_min(input int i);  return (i == 0) ? A_MIN : B_MIN; endfunction
   function automatic int p_max(input int i);  return (i == 0) ? A_MAX : B_MAX; endfunction
   function automatic int p_cap(input int i);  return (i == 0) ? ((1 << A_CW) - 1) : ((1 << B_CW) - 1); endfunction

   int m_k;            // edges since reset release
   bit m_lr[$];        // loop_raw sampled at edge 1, 2, ...
   bit m_filt[2];
   int m_last_flip[2];
   int m_count[2];
   bit m_req[2];
   bit m_serv[2];
   bit m_wait[2];
   int m_wstart[2];
   bit m_pulse[2];

   // Synchronised level visible just before edge j: loop_raw two edges back.
   function automatic bit s2_before(input int j);
      if (j >= 3) begin
         return m_lr[j - 3];
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_k = 0;
      m_lr.delete();
      for (int i = 0; i < 2; i++) begin
         m_filt[i]      = 1'b0;
         m_last_flip[i] = 0;
         m_count[i]     = 0;
         m_req[i]       = 1'b0;
         m_serv[i]      = 1'b0;
         m_wait[i]      = 1'b0;
         m_wstart[i]    = 0;
         m_pulse[i]     = 1'b0;
      end
   endtask

   task automatic model_edge(input bit lr, input logic [1:0] sr);
      m_k++;
      m_lr.push_back(lr);
      for (int i = 0; i < 2; i++) begin
         bit arr;
         bit differs;
         bit green;
         bit go;
         arr = 1'b0;
         // Level accepted when the last DEBOUNCE samples since the previous
         // acceptance all differ from the current filtered level.
         if (m_k - m_last_flip[i] >= p_db(i)) begin
            differs = 1'b1;
            for (int j = m_k - p_db(i) + 1; j <= m_k; j++) begin
               if (s2_before(j) == m_filt[i]) differs = 1'b0;
            end
            if (differs) begin
               m_filt[i]      = ~m_filt[i];
               m_last_flip[i] = m_k;
               arr            = m_filt[i];
            end
         end
         green = (sr == 2'b01);
         if (m_serv[i]) begin
            m_count[i] = 0;
            if (!green) m_serv[i] = 1'b0;
         end else if (green) begin
            m_serv[i]  = 1'b1;
            m_req[i]   = 1'b0;
            m_wait[i]  = 1'b0;
            m_count[i] = 0;
         end else if (m_req[i]) begin
            if (arr && m_count[i] < p_cap(i)) m_count[i]++;
         end else if (m_wait[i]) begin
            // timer value before edge m_k is m_k-1-entry, saturating at MAX_WAIT
            go = (m_count[i] >= p_min(i)) || (m_k - m_wstart[i] > p_max(i));
            if (arr && m_count[i] < p_cap(i)) m_count[i]++;
            if (go) begin
               m_req[i]  = 1'b1;
               m_wait[i] = 1'b0;
            end
         end else if (arr) begin
            m_wait[i]   = 1'b1;
            m_wstart[i] = m_k;
            m_count[i]  = 1;
         end
         m_pulse[i] = arr;
      end
   endtask

   task automatic compare_all();
      check("a_sensor",    int'(bus_a.sensor),    int'(m_req[0]));
      check("a_car_count", int'(bus_a.car_count), m_count[0]);
      check("a_car_pulse", int'(bus_a.car_pulse), int'(m_pulse[0]));
      check("b_sensor",    int'(bus_b.sensor),    int'(m_req[1]));
      check("b_car_count", int'(bus_b.car_count), m_count[1]);
      check("b_car_pulse", int'(bus_b.car_pulse), int'(m_pulse[1]));
   endtask

   // Drive inputs, take one edge, update the model, compare #1 later.
   task automatic step(input bit lr, input logic [1:0] sr);
      bus_a.loop_raw  = lr;
      bus_a.side_road = sr;
      bus_b.loop_raw  = lr;
      bus_b.side_road = sr;
      @(posedge clock);
      if (reset) model_reset();
      else       model_edge(lr, sr);
      #1;
      compare_all();
   endtask

   // One vehicle: loop high for hi edges then low for lo edges.
   task automatic vehicle(input int hi, input int lo, input logic [1:0] sr);
      for (int t = 0; t < hi; t++) step(1'b1, sr);
      for (int t = 0; t < lo; t++) step(1'b0, sr);
   endtask

   initial begin
      int first_pulse;
      int rise_edge;
      int cnt2_edge;
      int lr_left;
      int sr_left;
      bit lr_v;
      logic [1:0] sr_v;

      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      bus_a.loop_raw  = 1'b1;
      bus_a.side_road = 2'b10;
      bus_b.loop_raw  = 1'b1;
      bus_b.side_road = 2'b10;
      model_reset();

      // Reset held with the loop occupied: everything stays at zero.
      repeat (3) step(1'b1, 2'b10);
      reset = 1'b0;

      // First accepted arrival lands DEBOUNCE+1 edges after the release edge.
      first_pulse = -1;
      for (int t = 1; t <= 10; t++) begin
         step(1'b1, 2'b10);
         if (first_pulse < 0 && bus_a.car_pulse) first_pulse = t;
      end
      check("a_first_pulse_edge", first_pulse, 1 + A_DB + 1);

      // Single vehicle in WAITING, a 2-edge glitch in between; request is
      // forced MAX_WAIT+1 edges after WAITING was entered.
      rise_edge = -1;
      for (int t = 11; t <= 40; t++) begin
         step((t == 17 || t == 18) ? 1'b1 : 1'b0, 2'b10);
         if (rise_edge < 0 && bus_a.sensor) rise_edge = t;
      end
      check("a_wait_trigger_edge", rise_edge, first_pulse + A_MAX + 1);
      check("a_glitch_count", int'(bus_a.car_count), 1);

      // Green: request drops and queue clears on the green edge.
      step(1'b0, 2'b01);
      check("a_green_sensor", int'(bus_a.sensor), 0);
      check("a_green_count",  int'(bus_a.car_count), 0);
      // Vehicle during green pulses but is not counted.
      vehicle(6, 6, 2'b01);
      // Back to red/off: next vehicles count from 1.
      step(1'b0, 2'b00);
      vehicle(6, 6, 2'b00);
      check("a_count_after_service", int'(bus_a.car_count), 1);

      // Second vehicle reaches MIN_CARS; request one edge later.
      cnt2_edge = -1;
      rise_edge = -100;
      for (int t = 0; t < 12; t++) begin
         step((t < 6) ? 1'b1 : 1'b0, 2'b00);
         if (cnt2_edge < 0 && bus_a.car_count == 4'd2) cnt2_edge = t;
         if (rise_edge < 0 && bus_a.sensor) rise_edge = t;
      end
      check("a_queue_trigger_lag", rise_edge - cnt2_edge, 1);

      // Five more vehicles while red: the 2-bit counter saturates.
      repeat (5) vehicle(6, 6, 2'b10);
      check("b_saturation", int'(bus_b.car_count), 3);
      check("a_count_seven", int'(bus_a.car_count), 7);
      check("a_in_request", int'(bus_a.sensor), 1);

      // Asynchronous reset mid-REQUEST clears outputs before the next edge.
      reset = 1'b1;
      #2;
      model_reset();
      check("a_async_reset_sensor", int'(bus_a.sensor), 0);
      check("a_async_reset_count",  int'(bus_a.car_count), 0);
      check("b_async_reset_sensor", int'(bus_b.sensor), 0);
      step(1'b0, 2'b10);
      step(1'b0, 2'b10);
      reset = 1'b0;

      // Randomised traffic against the model.
      lr_left = 0;
      sr_left = 0;
      lr_v    = 1'b0;
      sr_v    = 2'b10;
      for (int n = 0; n < 3000; n++) begin
         if (lr_left == 0) begin
            lr_v    = ~lr_v;
            lr_left = int'($urandom_range(1, 9));
         end
         lr_left--;
         if (sr_left == 0) begin
            case ($urandom_range(0, 3))
               0:       sr_v = 2'b01;
               1:       sr_v = 2'b00;
               2:       sr_v = 2'b10;
               default: sr_v = 2'b11;
            endcase
            sr_left = int'($urandom_range(1, 40));
         end
         sr_left--;
         step(lr_v, sr_v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
